// File: rtl/trace_filter_multi_if.sv
// trace_filter_multi_if
// Groups the retired-instruction sample stream and the per-sample decision
// returned by the filter.
//   pc_valid     : next_instr holds a retired instruction this cycle
//   next_instr   : retired instruction word
//   out_valid    : a decision for the previous cycle's valid sample is present
//   drop_instr   : 1 = drop that sample, 0 = keep it
//   keep_reason  : pending-flag set that caused a keep, zero on drop
// master drives samples and receives decisions; slave is the filter side.
interface trace_filter_multi_if #(
    parameter int INSTR_WIDTH = 32,
    parameter int NUM_EVENTS  = 2
);
    logic                   pc_valid;
    logic [INSTR_WIDTH-1:0] next_instr;
    logic                   out_valid;
    logic                   drop_instr;
    logic [4+NUM_EVENTS:0]  keep_reason;

    modport master (
        output pc_valid,
        output next_instr,
        input  out_valid,
        input  drop_instr,
        input  keep_reason
    );

    modport slave (
        input  pc_valid,
        input  next_instr,
        output out_valid,
        output drop_instr,
        output keep_reason
    );
endinterface

// File: rtl/trace_filter_multi.sv
// trace_filter_multi
// Decides, one cycle after each retired-instruction sample, whether the
// sample is worth tracing. A sample is kept when it is not a repeat of the
// previous valid word (dedup enabled) and at least one "interesting" flag is
// pending: first sample after reset, a preceding branch/jump/WFI, an
// event-counter change, or an expired resync timer. Keeping a sample clears
// every pending flag.
// Ports:
//   clk, rst           : clock and synchronous active-high reset
//   trc                : sample stream in, registered decision out (slave)
//   event_counters     : packed free-running counters, channel k at
//                        [k*EVENT_WIDTH +: EVENT_WIDTH]
//   cfg_mask           : bit0 branch, bit1 jump, bit2 WFI, bit3 dedup,
//                        bit4+k event channel k
//   cfg_resync_period  : cycles between forced keeps, 0 disables
//   dropped_count      : saturating count of dropped samples
module trace_filter_multi #(
    parameter int INSTR_WIDTH    = 32,
    parameter int NUM_EVENTS     = 2,
    parameter int EVENT_WIDTH    = 7,
    parameter int TIMER_WIDTH    = 16,
    parameter int DROP_CNT_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    trace_filter_multi_if.slave               trc,
    input  logic [NUM_EVENTS*EVENT_WIDTH-1:0] event_counters,
    input  logic [3+NUM_EVENTS:0]             cfg_mask,
    input  logic [TIMER_WIDTH-1:0]            cfg_resync_period,
    output logic [DROP_CNT_WIDTH-1:0]         dropped_count
);

    localparam int REASON_WIDTH = 5 + NUM_EVENTS;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [INSTR_WIDTH-1:0] WFI_WORD = INSTR_WIDTH'(32'h10500073);

    logic                              first_q;
    logic                              branch_q;
    logic                              jump_q;
    logic                              wfi_q;
    logic                              resync_q;
    logic [NUM_EVENTS-1:0]             event_q;
    logic [NUM_EVENTS*EVENT_WIDTH-1:0] event_prev_q;
    logic [TIMER_WIDTH-1:0]            timer_q;
    logic [INSTR_WIDTH-1:0]            last_word_q;

    logic                              is_branch;
    logic                              is_jump;
    logic                              is_wfi;
    logic                              is_dup;
    logic                              resync_hit;
    logic                              class_ok;
    logic                              keep;
    logic                              drop;
    logic [REASON_WIDTH-1:0]           pending;
    logic [NUM_EVENTS-1:0]             event_set;

    // Instruction classification of the current sample.
    assign is_branch = (trc.next_instr[6:0] == OP_BRANCH);
    assign is_jump   = (trc.next_instr[6:0] == OP_JAL) || (trc.next_instr[6:0] == OP_JALR);
    assign is_wfi    = (trc.next_instr == WFI_WORD);

    // The timer reaching the period counts as pending in that very cycle, so
    // with period P the forced keep lands on every (P+1)th cycle after a keep.
    assign resync_hit = (cfg_resync_period != '0) && (timer_q == cfg_resync_period);

    assign pending = {event_q, resync_q | resync_hit, wfi_q, jump_q, branch_q, first_q};

    // A duplicate is dropped regardless of pending flags and neither consumes
    // them nor sets its own class flag.
    assign is_dup   = cfg_mask[3] && trc.pc_valid && (trc.next_instr == last_word_q);
    assign class_ok = trc.pc_valid && !is_dup;
    assign keep     = class_ok && (|pending);
    assign drop     = trc.pc_valid && !keep;

    // Per-channel change detection against last cycle's counter values; any
    // difference counts, including wrap from all-ones back to zero.
    always_comb begin
        event_set = '0;
        for (int k = 0; k < NUM_EVENTS; k++) begin
            event_set[k] = cfg_mask[4+k] &&
                (event_counters[k*EVENT_WIDTH +: EVENT_WIDTH] !=
                 event_prev_q[k*EVENT_WIDTH +: EVENT_WIDTH]);
        end
    end

    // Pending flags, resync timer and history registers. New flag sources
    // are ORed in after the keep clear so that a branch or event arriving in
    // the same cycle as a keep survives for the following sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_q      <= 1'b1;
            branch_q     <= 1'b0;
            jump_q       <= 1'b0;
            wfi_q        <= 1'b0;
            resync_q     <= 1'b0;
            event_q      <= '0;
            event_prev_q <= event_counters;
            timer_q      <= '0;
            last_word_q  <= '0;
        end else begin
            first_q      <= first_q & ~keep;
            branch_q     <= (branch_q & ~keep) | (class_ok & is_branch & cfg_mask[0]);
            jump_q       <= (jump_q & ~keep) | (class_ok & is_jump & cfg_mask[1]);
            wfi_q        <= (wfi_q & ~keep) | (class_ok & is_wfi & cfg_mask[2]);
            resync_q     <= ~keep & (resync_q | resync_hit);
            event_q      <= (event_q & ~{NUM_EVENTS{keep}}) | event_set;
            event_prev_q <= event_counters;
            if (keep) begin
                timer_q <= '0;
            end else if (timer_q < cfg_resync_period) begin
                timer_q <= timer_q + 1'b1;
            end else begin
                timer_q <= cfg_resync_period;
            end
            if (trc.pc_valid) begin
                last_word_q <= trc.next_instr;
            end
        end
    end

    // Registered decision outputs and the saturating drop counter. Reset
    // discards any decision that was about to be presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            trc.out_valid   <= 1'b0;
            trc.drop_instr  <= 1'b0;
            trc.keep_reason <= '0;
            dropped_count   <= '0;
        end else begin
            trc.out_valid   <= trc.pc_valid;
            trc.drop_instr  <= drop;
            trc.keep_reason <= keep ? pending : '0;
            if (drop && (dropped_count != '1)) begin
                dropped_count <= dropped_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trace_filter_multi.sv
// tb_trace_filter_multi
// Directed scenarios with pinned literal expectations, followed by
// randomized traffic, all compared every cycle against a behavioural model
// of the filter rules. dropped_count is narrowed so saturation is reached.
module tb_trace_filter_multi;

    localparam int IW = 32;
    localparam int NE = 2;
    localparam int EW = 7;
    localparam int TW = 16;
    localparam int DW = 6;
    localparam int RW = 5 + NE;
    localparam int MW = 4 + NE;

    localparam logic [31:0] W0   = 32'h00200093;
    localparam logic [31:0] ADD  = 32'h00130013;
    localparam logic [31:0] BR   = 32'h00029663;
    localparam logic [31:0] JAL  = 32'h0000006F;
    localparam logic [31:0] JALR = 32'h00008067;
    localparam logic [31:0] WFI  = 32'h10500073;

    logic           clk = 1'b0;
    logic           rst;
    logic [NE*EW-1:0] event_counters;
    logic [MW-1:0]  cfg_mask;
    logic [TW-1:0]  cfg_resync_period;
    logic [DW-1:0]  dropped_count;

    trace_filter_multi_if #(.INSTR_WIDTH(IW), .NUM_EVENTS(NE)) trc ();

    trace_filter_multi #(
        .INSTR_WIDTH(IW), .NUM_EVENTS(NE), .EVENT_WIDTH(EW),
        .TIMER_WIDTH(TW), .DROP_CNT_WIDTH(DW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .trc              (trc),
        .event_counters   (event_counters),
        .cfg_mask         (cfg_mask),
        .cfg_resync_period(cfg_resync_period),
        .dropped_count    (dropped_count)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    bit checking = 1'b0;

    int tb_mask   = 0;
    int tb_period = 0;
    int tb_ev [NE];

    bit [RW-1:0] m_pend;
    int          m_timer;
    logic [31:0] m_last;
    int          m_prev [NE];

    int e_valid, e_drop, e_reason, e_count;

    bit    lit_armed = 1'b0;
    string lit_name;
    int    lit_valid, lit_drop, lit_reason, lit_cnt;

    task automatic cmp(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        if (!checking) return;
        cmp("out_valid", int'(trc.out_valid), e_valid);
        cmp("drop_instr", int'(trc.drop_instr), e_drop);
        cmp("keep_reason", int'(trc.keep_reason), e_reason);
        cmp("dropped_count", int'(dropped_count), e_count);
        if (lit_armed) begin
            cmp({lit_name, "_valid"}, int'(trc.out_valid), lit_valid);
            cmp({lit_name, "_drop"}, int'(trc.drop_instr), lit_drop);
            cmp({lit_name, "_reason"}, int'(trc.keep_reason), lit_reason);
            if (lit_cnt >= 0) cmp({lit_name, "_count"}, int'(dropped_count), lit_cnt);
            lit_armed = 1'b0;
        end
    endtask

    task automatic expectNext(input string name, input int v, input int d, input int reason, input int cnt);
        lit_armed  = 1'b1;
        lit_name   = name;
        lit_valid  = v;
        lit_drop   = d;
        lit_reason = reason;
        lit_cnt    = cnt;
    endtask

    // Reference model: what the decision after the coming edge must be, from
    // the filter rules applied to the inputs of this cycle.
    task automatic modelStep(input bit r, input bit v, input logic [31:0] w);
        bit [RW-1:0] now;
        bit [MW-1:0] mk;
        bit dup, keep;
        mk = MW'(tb_mask);
        if (r) begin
            e_valid = 0; e_drop = 0; e_reason = 0; e_count = 0;
            m_pend = '0;
            m_pend[0] = 1'b1;
            m_timer = 0;
            m_last = '0;
            for (int k = 0; k < NE; k++) m_prev[k] = tb_ev[k];
            return;
        end
        now = m_pend;
        if (tb_period != 0 && m_timer == tb_period) now[4] = 1'b1;
        dup  = v && mk[3] && (w == m_last);
        keep = v && !dup && (now != '0);
        e_valid  = int'(v);
        e_drop   = int'(v && !keep);
        e_reason = keep ? int'(now) : 0;
        if (v && !keep && e_count < (1 << DW) - 1) e_count++;
        m_pend = keep ? '0 : now;
        if (v && !dup) begin
            if (w[6:0] == 7'h63 && mk[0]) m_pend[1] = 1'b1;
            if ((w[6:0] == 7'h6F || w[6:0] == 7'h67) && mk[1]) m_pend[2] = 1'b1;
            if (w == WFI && mk[2]) m_pend[3] = 1'b1;
        end
        for (int k = 0; k < NE; k++) begin
            if (tb_ev[k] != m_prev[k] && mk[4+k]) m_pend[5+k] = 1'b1;
            m_prev[k] = tb_ev[k];
        end
        if (keep) m_timer = 0;
        else if (m_timer < tb_period) m_timer++;
        else m_timer = tb_period;
        if (v) m_last = w;
    endtask

    task automatic applyStimulus(input bit r, input bit v, input logic [31:0] w);
        @(negedge clk);
        checkOutput();
        rst               = r;
        trc.pc_valid      = v;
        trc.next_instr    = w;
        cfg_mask          = MW'(tb_mask);
        cfg_resync_period = TW'(tb_period);
        for (int k = 0; k < NE; k++) event_counters[k*EW +: EW] = EW'(tb_ev[k]);
        modelStep(r, v, w);
        if (r) checking = 1'b1;
    endtask

    task automatic step(input bit v, input logic [31:0] w);
        applyStimulus(1'b0, v, w);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b1, $urandom);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] w, prev_w;
        bit v;
        for (int k = 0; k < NE; k++) tb_ev[k] = 0;
        rst = 1'b1;
        trc.pc_valid = 1'b0;
        trc.next_instr = '0;
        event_counters = '0;
        cfg_mask = '0;
        cfg_resync_period = '0;

        // First keep after reset, then plain repeats are dropped.
        doReset();
        expectNext("reset_state", 0, 0, 0, 0);
        step(1, ADD); expectNext("add_first", 1, 0, 1, -1);
        step(1, ADD); expectNext("add_second", 1, 1, 0, 1);
        step(1, ADD); expectNext("add_third", 1, 1, 0, 2);
        step(0, '0);

        // Branch flag sets on a dropped branch and fires on the next word.
        tb_mask = 1;
        doReset();
        step(1, W0);  expectNext("br_warm", 1, 0, 1, -1);
        step(1, BR);  expectNext("br_drop", 1, 1, 0, -1);
        step(0, '0); step(0, '0); step(0, '0);
        step(1, ADD); expectNext("br_keep", 1, 0, 2, -1);
        step(1, ADD); expectNext("br_after", 1, 1, 0, 2);

        // Jump and WFI reasons.
        tb_mask = 6;
        doReset();
        step(1, W0);    expectNext("jw_warm", 1, 0, 1, -1);
        step(1, JAL);   expectNext("jal_drop", 1, 1, 0, -1);
        step(1, ADD);   expectNext("jal_keep", 1, 0, 4, -1);
        step(1, WFI);   expectNext("wfi_drop", 1, 1, 0, -1);
        step(1, W0);    expectNext("wfi_keep", 1, 0, 8, -1);
        step(1, JALR);  expectNext("jalr_drop", 1, 1, 0, -1);
        step(1, ADD);   expectNext("jalr_keep", 1, 0, 4, -1);

        // Dedup across idle cycles leaves the pending branch intact.
        tb_mask = 9;
        doReset();
        step(1, W0);  expectNext("dd_warm", 1, 0, 1, -1);
        step(1, BR);  expectNext("dd_br", 1, 1, 0, -1);
        step(0, '0); step(0, '0);
        step(1, BR);  expectNext("dd_dup", 1, 1, 0, -1);
        step(1, ADD); expectNext("dd_keep", 1, 0, 2, -1);

        // Event channel 1 wrap 0x7F -> 0x00 while idle.
        tb_mask = 'h20;
        tb_ev[1] = 127;
        doReset();
        step(1, W0); expectNext("ev_warm", 1, 0, 1, -1);
        tb_ev[1] = 0;
        step(0, '0); step(0, '0);
        step(1, 32'hAAAAAAAA); expectNext("ev_keep", 1, 0, 'h40, -1);
        tb_mask = 0;
        tb_ev[1] = 127;
        step(0, '0);
        tb_ev[1] = 0;
        step(0, '0);
        step(1, 32'h55555555); expectNext("ev_masked", 1, 1, 0, -1);

        // Resync every 5th sample with period 4, none with period 0.
        tb_period = 4;
        doReset();
        step(1, W0); expectNext("rs_warm", 1, 0, 1, -1);
        for (int i = 1; i <= 10; i++) begin
            step(1, 32'h13 | (i << 15));
            if (i % 5 == 0) expectNext("rs_keep", 1, 0, 'h10, -1);
            else            expectNext("rs_drop", 1, 1, 0, -1);
        end
        tb_period = 0;
        for (int i = 11; i <= 20; i++) begin
            step(1, 32'h13 | (i << 15));
            expectNext("rs_off", 1, 1, 0, -1);
        end

        // Reset mid-stream with a branch pending and a sample in flight.
        tb_mask = 1;
        doReset();
        step(1, W0); expectNext("mr_warm", 1, 0, 1, -1);
        step(1, BR);
        step(1, ADD);
        doReset();   expectNext("mr_reset", 0, 0, 0, 0);
        step(1, ADD); expectNext("mr_first", 1, 0, 1, 0);

        // Randomized traffic.
        prev_w = ADD;
        for (int blk = 0; blk < 10; blk++) begin
            tb_mask   = $urandom_range(0, (1 << MW) - 1);
            tb_period = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
            for (int c = 0; c < 300; c++) begin
                if ($urandom_range(0, 99) == 0) tb_mask = $urandom_range(0, (1 << MW) - 1);
                for (int k = 0; k < NE; k++) begin
                    case ($urandom_range(0, 15))
                        0: tb_ev[k] = (tb_ev[k] + 1) % (1 << EW);
                        1: tb_ev[k] = $urandom_range(0, (1 << EW) - 1);
                        default: ;
                    endcase
                end
                v = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 8))
                    0: w = ADD;
                    1: w = BR;
                    2: w = JAL;
                    3: w = JALR;
                    4: w = WFI;
                    5: w = 32'h00000073;
                    6: w = prev_w;
                    default: w = $urandom;
                endcase
                if (v) prev_w = w;
                if ($urandom_range(0, 499) == 0) doReset();
                else step(v, w);
            end
        end

        step(0, '0);
        step(0, '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
